fcpu_cdb_arbiter: RTL and testbench
===================================

// Module: fcpu_cdb_arbiter
// PURPOSE
//  Round-robin arbiter for the common data bus (CDB = tag + result word).
//  Up to N_REQ functional units (ALU, load/store, branch, ...) each offer one
//  completed result with its reservation-station tag. One winner is granted per
//  cycle, and its result is broadcast one cycle later on a registered CDB that
//  feeds the reservation stations and the reorder buffer.
// PARAMETERS
//  N_REQ   4                   number of requesting units (>=2, need not be a power of 2)
//  TAG_W   fcpu_pkg::RSV_ID_W  tag width (5)
//  DATA_W  fcpu_pkg::DATA_W    result width (32)
//  SRC_W   $clog2(N_REQ)       width of the source index (derived, not overridable)
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             asynchronous reset, active-high
//  flush      in   1             pipeline flush (mispredict); kills the pending broadcast
//  req_valid  in   N_REQ         unit i has a result
//  req_tag    in   N_REQ*TAG_W   unit i tag; slice i = [i*TAG_W +: TAG_W]
//  req_data   in   N_REQ*DATA_W  unit i result; slice i = [i*DATA_W +: DATA_W]
//  req_ready  out  N_REQ         one-hot grant; unit i result accepted this cycle
//  cdb_valid  out  1             broadcast valid
//  cdb_tag    out  TAG_W         broadcast tag
//  cdb_data   out  DATA_W        broadcast result
//  cdb_src    out  SRC_W         index of the unit that produced the broadcast
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-high. While rst is high:
//    cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0, req_ready=0.
//  - Handshake: a transfer occurs when req_valid[i] && req_ready[i].
//    Once unit i raises req_valid[i], it holds valid, tag and data stable
//    until the transfer occurs or flush is seen.
//  - req_ready is combinational from req_valid, rr_ptr and flush. It is at
//    most one-hot, and it is all-zero when flush=1 or no unit is valid.
//  - Arbitration: scan indices rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...,
//    rr_ptr-1 and grant the first index with req_valid set. Wrap is mod N_REQ.
//  - rr_ptr update:
//    - On a grant g: rr_ptr <= (g==N_REQ-1) ? 0 : g+1.
//    - With no grant, or when flush=1: rr_ptr is held.
//  - Latency: exactly 1 cycle. On the edge after grant g:
//    cdb_valid=1, cdb_tag=req_tag[g], cdb_data=req_data[g], cdb_src=g.
//    Back-to-back grants give one broadcast per cycle (full throughput).
//  - No grant in a cycle: cdb_valid<=0 on the next edge.
//    cdb_tag, cdb_data and cdb_src hold their last values; consumers qualify with cdb_valid.
//  - The CDB has no backpressure: every listener accepts when cdb_valid=1.
//  - flush=1 in cycle t:
//    - no grant in cycle t;
//    - cdb_valid=0 after the edge ending cycle t;
//    - a broadcast already registered and visible in cycle t is still shown in cycle t.
//    Units drop their own valid on flush; the arbiter keeps no per-unit state.
//  - flush and a request in the same cycle: flush wins and the request is not accepted.
//  - Single requester: it is granted every cycle it is valid, whatever rr_ptr is.
//  - Starvation bound: a continuously valid unit is granted within N_REQ cycles.
// TESTING
//  1. Reset: assert rst mid-broadcast (cdb_valid=1).
//     -> cdb_valid, cdb_tag, cdb_data and cdb_src are 0 without a clock edge; req_ready=0.
//  2. All 4 units valid for 8 cycles, tags 1..4, data 0xA0..0xA3.
//     -> grants 0,1,2,3,0,1,2,3; cdb_tag 1,2,3,4,... each one cycle after its grant.
//  3. Only unit 2 valid, tag 9, data 0xDEADBEEF, with rr_ptr=3.
//     -> req_ready=4'b0100; next cycle cdb_valid=1, cdb_tag=9, cdb_data=0xDEADBEEF, cdb_src=2.
//  4. Units 1 and 3 valid, flush=1 in the same cycle.
//     -> req_ready=0, cdb_valid=0 next cycle, rr_ptr unchanged; the grant goes to the expected unit the cycle after.
//  5. N_REQ=3, all valid, rr_ptr=2. -> grant 2, then 0 (wrap), then 1.
//  6. Idle cycle after broadcast tag 7, data 0x55.
//     -> cdb_valid=0 while cdb_tag=7 and cdb_data=0x55 hold; random-stimulus check: one-hot grant and per-unit fairness within N_REQ cycles.

Source files
------------

// File: rtl/fcpu_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// fcpu_cdb_arbiter
//   Round-robin arbiter for the common data bus (tag + result word).
//   Up to N_REQ functional units each offer one completed result. One unit is
//   granted per cycle, and its tag/result is broadcast on a registered CDB on
//   the following edge.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   flush      : pipeline flush; blocks grants and kills the next broadcast
//   req_valid  : [N_REQ]        unit i has a result
//   req_tag    : [N_REQ*TAG_W]  unit i tag, slice [i*TAG_W +: TAG_W]
//   req_data   : [N_REQ*DATA_W] unit i result, slice [i*DATA_W +: DATA_W]
//   req_ready  : [N_REQ]        one-hot grant (combinational)
//   cdb_valid  : broadcast valid
//   cdb_tag    : broadcast tag
//   cdb_data   : broadcast result
//   cdb_src    : index of the unit that produced the broadcast
// -----------------------------------------------------------------------------
module fcpu_cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [$clog2(N_REQ)-1:0]  cdb_src
);

  localparam int SRC_W = $clog2(N_REQ);

  // Pointer advance with explicit wrap, so non-power-of-two N_REQ works.
  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] g);
    return (g == SRC_W'(N_REQ - 1)) ? '0 : g + SRC_W'(1);
  endfunction

  logic [SRC_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q,   cdb_src_d;

  logic [N_REQ-1:0]  lower_mask;
  logic [N_REQ-1:0]  masked_req;
  logic [N_REQ-1:0]  pick;
  logic [N_REQ-1:0]  gnt;
  logic              grant_vld;
  logic [SRC_W-1:0]  grant_idx;

  // Arbitration: requests at or above rr_ptr have priority; if none, the
  // lowest-index request wins (the wrapped part of the scan). The lowest set
  // bit of the chosen vector is isolated with x & -x.
  always_comb begin
    lower_mask = (N_REQ'(1) << rr_ptr_q) - N_REQ'(1);
    masked_req = req_valid & ~lower_mask;
    pick       = (|masked_req) ? masked_req : req_valid;
    gnt        = '0;
    if (!flush && !rst) begin
      gnt = pick & (~pick + N_REQ'(1));
    end
    grant_vld = |gnt;
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        grant_idx = SRC_W'(i);
      end
    end
  end

  assign req_ready = gnt;

  // Next-state: payload registers only load on a grant so the last broadcast
  // stays visible on idle cycles.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = grant_vld;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (grant_vld) begin
      rr_ptr_d  = next_ptr(grant_idx);
      cdb_src_d = grant_idx;
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i]) begin
          cdb_tag_d  = req_tag[i*TAG_W +: TAG_W];
          cdb_data_d = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Broadcast stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_fcpu_cdb_arbiter.sv
module tb_fcpu_cdb_arbiter;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
    logic [1:0]  src;
    int          due;
  } exp_t;

  logic         clk;
  logic         rst;
  int           cyc;
  int           checks;
  int           errors;
  exp_t         q4[$];
  exp_t         q3[$];

  // 4-unit instance
  logic         flush;
  logic [3:0]   req_valid;
  logic [19:0]  req_tag;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         cdb_valid;
  logic [4:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [1:0]   cdb_src;

  // 3-unit instance
  logic         flush3;
  logic [2:0]   v3;
  logic [14:0]  t3;
  logic [95:0]  d3;
  logic [2:0]   r3;
  logic         c3_valid;
  logic [4:0]   c3_tag;
  logic [31:0]  c3_data;
  logic [1:0]   c3_src;

  fcpu_cdb_arbiter #(.N_REQ(4), .TAG_W(5), .DATA_W(32)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  fcpu_cdb_arbiter #(.N_REQ(3), .TAG_W(5), .DATA_W(32)) dut3 (
    .clk(clk), .rst(rst), .flush(flush3),
    .req_valid(v3), .req_tag(t3), .req_data(d3),
    .req_ready(r3),
    .cdb_valid(c3_valid), .cdb_tag(c3_tag), .cdb_data(c3_data), .cdb_src(c3_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int i, input logic v, input logic [4:0] t, input logic [31:0] d);
    req_valid[i]          = v;
    req_tag[i*5 +: 5]     = t;
    req_data[i*32 +: 32]  = d;
  endtask

  task automatic set_unit3(input int i, input logic v, input logic [4:0] t, input logic [31:0] d);
    v3[i]           = v;
    t3[i*5 +: 5]    = t;
    d3[i*32 +: 32]  = d;
  endtask

  // Check the combinational grant and, if a grant is expected, queue the
  // broadcast it must produce on the next edge.
  task automatic cycle_push(input logic [3:0] exp_rdy, input int g);
    exp_t e;
    #1;
    chk("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
    if (exp_rdy != 4'd0) begin
      e.tag  = req_tag[g*5 +: 5];
      e.data = req_data[g*32 +: 32];
      e.src  = 2'(g);
      e.due  = cyc + 1;
      q4.push_back(e);
    end
  endtask

  task automatic cycle_push3(input logic [2:0] exp_rdy, input int g);
    exp_t e;
    #1;
    chk("req_ready_n3", {61'd0, r3}, {61'd0, exp_rdy});
    if (exp_rdy != 3'd0) begin
      e.tag  = t3[g*5 +: 5];
      e.data = d3[g*32 +: 32];
      e.src  = 2'(g);
      e.due  = cyc + 1;
      q3.push_back(e);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (cdb_valid) begin
        if (q4.size() == 0) begin
          chk("cdb_unexpected", {63'd0, cdb_valid}, 64'd0);
        end else begin
          e = q4.pop_front();
          chk("cdb_latency", 64'(cyc), 64'(e.due));
          chk("cdb_tag", {59'd0, cdb_tag}, {59'd0, e.tag});
          chk("cdb_data", {32'd0, cdb_data}, {32'd0, e.data});
          chk("cdb_src", {62'd0, cdb_src}, {62'd0, e.src});
        end
      end else if (q4.size() > 0 && q4[0].due <= cyc) begin
        e = q4.pop_front();
        chk("cdb_missing", {63'd0, cdb_valid}, 64'd1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (c3_valid) begin
        if (q3.size() == 0) begin
          chk("cdb3_unexpected", {63'd0, c3_valid}, 64'd0);
        end else begin
          e = q3.pop_front();
          chk("cdb3_latency", 64'(cyc), 64'(e.due));
          chk("cdb3_tag", {59'd0, c3_tag}, {59'd0, e.tag});
          chk("cdb3_data", {32'd0, c3_data}, {32'd0, e.data});
          chk("cdb3_src", {62'd0, c3_src}, {62'd0, e.src});
        end
      end else if (q3.size() > 0 && q3[0].due <= cyc) begin
        e = q3.pop_front();
        chk("cdb3_missing", {63'd0, c3_valid}, 64'd1);
      end
    end
  end

  // Global time bound
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  int exp2[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  logic        uv[4];
  logic [4:0]  ut[4];
  logic [31:0] ud[4];
  int          wt[4];
  int          ref_ptr;
  int          eg;
  int          idx;
  logic        fl;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    flush = 1'b0;
    flush3 = 1'b0;
    req_valid = '0;
    req_tag = '0;
    req_data = '0;
    v3 = '0;
    t3 = '0;
    d3 = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    chk("rst_cdb_tag", {59'd0, cdb_tag}, 64'd0);
    chk("rst_cdb_data", {32'd0, cdb_data}, 64'd0);
    chk("rst_cdb_src", {62'd0, cdb_src}, 64'd0);
    chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // All four units valid: strict rotation 0,1,2,3,0,...
    next_cycle();
    for (int u = 0; u < 4; u++) set_unit(u, 1'b1, 5'(u + 1), 32'hA0 + 32'(u));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      cycle_push(4'(1 << exp2[k]), exp2[k]);
    end

    // Single requester (unit 2): granted at rr_ptr=0, then again at rr_ptr=3
    next_cycle();
    for (int u = 0; u < 4; u++) set_unit(u, 1'b0, 5'd0, 32'd0);
    set_unit(2, 1'b1, 5'd9, 32'hDEADBEEF);
    cycle_push(4'b0100, 2);
    next_cycle();
    cycle_push(4'b0100, 2);

    // Flush with units 1 and 3 valid; the unit-2 broadcast is still shown
    next_cycle();
    set_unit(2, 1'b0, 5'd0, 32'd0);
    set_unit(1, 1'b1, 5'd11, 32'h1111);
    set_unit(3, 1'b1, 5'd13, 32'h3333);
    flush = 1'b1;
    cycle_push(4'b0000, 0);
    next_cycle();
    flush = 1'b0;
    chk("cdb_valid_after_flush", {63'd0, cdb_valid}, 64'd0);
    cycle_push(4'b1000, 3);
    next_cycle();
    set_unit(3, 1'b0, 5'd0, 32'd0);
    cycle_push(4'b0010, 1);

    // Broadcast tag 7 / 0x55 followed by idle cycles
    next_cycle();
    set_unit(1, 1'b0, 5'd0, 32'd0);
    set_unit(0, 1'b1, 5'd7, 32'h55);
    cycle_push(4'b0001, 0);
    next_cycle();
    set_unit(0, 1'b0, 5'd0, 32'd0);
    cycle_push(4'b0000, 0);
    next_cycle();
    cycle_push(4'b0000, 0);
    chk("idle_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    chk("idle_cdb_tag", {59'd0, cdb_tag}, 64'd7);
    chk("idle_cdb_data", {32'd0, cdb_data}, 64'h55);
    chk("idle_cdb_src", {62'd0, cdb_src}, 64'd0);

    // Reset mid-broadcast; leave rr_ptr at 3 beforehand
    next_cycle();
    set_unit(2, 1'b1, 5'd5, 32'h77);
    cycle_push(4'b0100, 2);
    next_cycle();
    set_unit(2, 1'b0, 5'd0, 32'd0);
    chk("pre_rst_cdb_valid", {63'd0, cdb_valid}, 64'd1);
    #1;
    rst = 1'b1;
    for (int u = 0; u < 4; u++) set_unit(u, 1'b1, 5'(u + 1), 32'hA0 + 32'(u));
    #1;
    chk("async_rst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    chk("async_rst_cdb_tag", {59'd0, cdb_tag}, 64'd0);
    chk("async_rst_cdb_data", {32'd0, cdb_data}, 64'd0);
    chk("async_rst_cdb_src", {62'd0, cdb_src}, 64'd0);
    chk("async_rst_req_ready", {60'd0, req_ready}, 64'd0);
    q4.delete();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    cycle_push(4'b0001, 0);

    // N_REQ=3: bring rr_ptr to 2, then all valid -> 2, 0, 1
    next_cycle();
    for (int u = 0; u < 4; u++) set_unit(u, 1'b0, 5'd0, 32'd0);
    set_unit3(1, 1'b1, 5'd21, 32'h101);
    cycle_push3(3'b010, 1);
    next_cycle();
    for (int u = 0; u < 3; u++) set_unit3(u, 1'b1, 5'(20 + u), 32'h100 + 32'(u));
    cycle_push3(3'b100, 2);
    next_cycle();
    cycle_push3(3'b001, 0);
    next_cycle();
    cycle_push3(3'b010, 1);
    next_cycle();
    for (int u = 0; u < 3; u++) set_unit3(u, 1'b0, 5'd0, 32'd0);

    // Random traffic on the 4-unit instance; rr_ptr is 1 after the post-reset grant
    ref_ptr = 1;
    for (int i = 0; i < 4; i++) begin
      uv[i] = 1'b0; ut[i] = '0; ud[i] = '0; wt[i] = 0;
    end
    for (int n = 0; n < 300; n++) begin
      next_cycle();
      fl = ($urandom_range(15) == 0);
      flush = fl;
      for (int i = 0; i < 4; i++) set_unit(i, uv[i], ut[i], ud[i]);
      eg = -1;
      if (!fl) begin
        for (int k = 0; k < 4; k++) begin
          idx = (ref_ptr + k) % 4;
          if (uv[idx] && eg < 0) eg = idx;
        end
      end
      cycle_push((eg >= 0) ? 4'(1 << eg) : 4'd0, (eg >= 0) ? eg : 0);
      chk("rand_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (eg >= 0) begin
        chk("rand_fairness", 64'(wt[eg] <= 3), 64'd1);
        ref_ptr = (eg == 3) ? 0 : eg + 1;
      end
      for (int i = 0; i < 4; i++) begin
        if (fl || i == eg) begin
          uv[i] = 1'b0;
          wt[i] = 0;
        end else if (uv[i]) begin
          wt[i]++;
        end else if ($urandom_range(1) == 1) begin
          uv[i] = 1'b1;
          ut[i] = 5'($urandom);
          ud[i] = $urandom;
        end
      end
    end

    next_cycle();
    flush = 1'b0;
    for (int u = 0; u < 4; u++) set_unit(u, 1'b0, 5'd0, 32'd0);
    repeat (3) next_cycle();
    chk("q4_drained", 64'(q4.size()), 64'd0);
    chk("q3_drained", 64'(q3.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
